asroba_acc_stage: RTL and testbench

Streaming accumulate stage directly downstream of the 16x16 logarithmic approximate multiplier. Consumes its 32-bit products one per cycle over a valid/ready handshake and sums a vector of them into a wide signed accumulator. Presents the dot-product result with a beat count and an overflow flag. Corrects the multiplier's ones'-complement sign output by injecting a +1 carry for negative products, so the sum is two's-complement exact with respect to the approximate magnitudes.

---
 rtl/asroba_pkg.sv | 13 +
 rtl/asroba_acc_add.sv | 42 ++++
 rtl/asroba_acc_stage.sv | 125 ++++++++++++
 tb/tb_asroba_acc_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/asroba_pkg.sv
// Shared definitions for the asroba accumulate stage: product width, default sizes, FSM states.
package asroba_pkg;

    localparam int PROD_W    = 32;
    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

endpackage

// File: rtl/asroba_acc_add.sv
// Combinational accumulator adder: acc + sign-extended product + carry-in, with overflow detect.
// Optional clamping on overflow when ACC_SATURATE_EN is defined.
module asroba_acc_add
    import asroba_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic signed [PROD_W-1:0] prod_i,
    input  logic                     cin_i,
    output logic signed [ACC_W-1:0]  sum_o,
    output logic                     ovf_o
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // The true sum of two same-sign operands that overflowed carries the operands' sign.
    function automatic logic [ACC_W-1:0] sat_clamp(input logic [ACC_W-1:0] raw,
                                                    input logic            ovf,
                                                    input logic            true_neg);
        if (!ovf) begin
            return raw;
        end
        return true_neg ? ACC_MIN : ACC_MAX;
    endfunction

    logic signed [ACC_W-1:0] term;
    logic        [ACC_W-1:0] raw_sum;

    always_comb begin
        term    = {{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
        raw_sum = acc_i + term + {{(ACC_W-1){1'b0}}, cin_i};
        ovf_o   = (acc_i[ACC_W-1] == term[ACC_W-1]) && (raw_sum[ACC_W-1] != acc_i[ACC_W-1]);
`ifdef ACC_SATURATE_EN
        sum_o   = sat_clamp(raw_sum, ovf_o, acc_i[ACC_W-1]);
`else
        sum_o   = raw_sum;
`endif
    end

endmodule

// File: rtl/asroba_acc_stage.sv
// Streaming dot-product accumulate stage behind the log multiplier (valid/ready in and out).
// Build option: define ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module asroba_acc_stage
    import asroba_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic        [PROD_W-1:0] in_prod,
    input  logic                     in_neg,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic        [CNT_W-1:0]  out_cnt,
    output logic                     out_ovf
);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
    logic        [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic                    out_ovf_q, out_ovf_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;

    logic signed [ACC_W-1:0] add_sum;
    logic                    add_ovf;
    logic        [CNT_W-1:0] cnt_inc;
    logic                    accept;

    asroba_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i  (acc_q),
        .prod_i (in_prod),
        .cin_i  (in_neg),
        .sum_o  (add_sum),
        .ovf_o  (add_ovf)
    );

    assign accept  = in_valid && in_ready_q;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_acc_d   = out_acc_q;
        out_cnt_d   = out_cnt_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (in_last) begin
                        // Final beat: publish the result and restart the running sum from zero.
                        out_acc_d   = add_sum;
                        out_cnt_d   = cnt_inc;
                        out_ovf_d   = ovf_q | add_ovf;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = ST_DONE;
                    end else begin
                        acc_d = add_sum;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | add_ovf;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_acc_q   <= out_acc_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_asroba_acc_stage.sv
// Directed bench for asroba_acc_stage: a default 40-bit instance and a 33-bit instance share stimulus.
module tb_asroba_acc_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_prod;
    logic        in_neg;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [39:0] out_acc_a;
    logic [7:0]  out_cnt_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [32:0] out_acc_b;
    logic [7:0]  out_cnt_b;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    asroba_acc_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_prod   (in_prod),
        .in_neg    (in_neg),
        .in_last   (in_last),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_acc   (out_acc_a),
        .out_cnt   (out_cnt_a),
        .out_ovf   (out_ovf_a)
    );

    asroba_acc_stage #(.ACC_W(33), .CNT_W(8)) dut33 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_prod   (in_prod),
        .in_neg    (in_neg),
        .in_last   (in_last),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_acc   (out_acc_b),
        .out_cnt   (out_cnt_b),
        .out_ovf   (out_ovf_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] p, input logic n, input logic l);
        in_valid = 1'b1;
        in_prod  = p;
        in_neg   = n;
        in_last  = l;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_neg   = 1'b0;
        in_prod  = '0;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_out_acc", 64'(out_acc_a), 64'd0);
        chk("rst_out_cnt", 64'(out_cnt_a), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf_a), 64'd0);
        rst = 1'b0;

        // Three positive beats; result appears the cycle after the last one, for one cycle.
        beat(32'd100, 1'b0, 1'b0);
        beat(32'd200, 1'b0, 1'b0);
        chk("v1_no_early_valid", 64'(out_valid_a), 64'd0);
        beat(32'd300, 1'b0, 1'b1);
        chk("v1_valid", 64'(out_valid_a), 64'd1);
        chk("v1_acc", 64'(out_acc_a), 64'd600);
        chk("v1_cnt", 64'(out_cnt_a), 64'd3);
        chk("v1_ovf", 64'(out_ovf_a), 64'd0);
        chk("v1_in_ready_done", 64'(in_ready_a), 64'd0);
        idle();
        tick();
        chk("v1_valid_drop", 64'(out_valid_a), 64'd0);
        chk("v1_in_ready_back", 64'(in_ready_a), 64'd1);

        // Negative product correction, zero-with-negative, and a gap carrying junk last.
        beat(32'hFFFF_FFF0, 1'b1, 1'b0);
        beat(32'hFFFF_FFFF, 1'b1, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_prod  = 32'd999;
        tick();
        tick();
        chk("v2_gap_no_valid", 64'(out_valid_a), 64'd0);
        beat(32'd20, 1'b0, 1'b1);
        chk("v2_acc", 64'(out_acc_a), 64'd5);
        chk("v2_cnt", 64'(out_cnt_a), 64'd3);
        idle();
        tick();

        // Backpressure: result held, input beats refused.
        out_ready = 1'b0;
        beat(32'd9, 1'b0, 1'b1);
        in_prod = 32'd50;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 64'(out_valid_a), 64'd1);
            chk("bp_in_ready", 64'(in_ready_a), 64'd0);
            chk("bp_acc", 64'(out_acc_a), 64'd9);
            chk("bp_cnt", 64'(out_cnt_a), 64'd1);
        end
        idle();
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 64'(out_valid_a), 64'd0);
        chk("bp_release_ready", 64'(in_ready_a), 64'd1);
        beat(32'd4, 1'b0, 1'b0);
        beat(32'd6, 1'b0, 1'b1);
        chk("bp_next_acc", 64'(out_acc_a), 64'd10);
        chk("bp_next_cnt", 64'(out_cnt_a), 64'd2);
        idle();
        tick();

        // Three max-positive products: fits in 40 bits, overflows 33 bits on the third step.
        beat(32'h7FFF_FFFF, 1'b0, 1'b0);
        beat(32'h7FFF_FFFF, 1'b0, 1'b0);
        beat(32'h7FFF_FFFF, 1'b0, 1'b1);
        chk("ovf40_acc", 64'(out_acc_a), 64'h1_7FFF_FFFD);
        chk("ovf40_flag", 64'(out_ovf_a), 64'd0);
        chk("ovf33_flag", 64'(out_ovf_b), 64'd1);
`ifdef ACC_SATURATE_EN
        chk("ovf33_acc", 64'(out_acc_b), 64'h0_FFFF_FFFF);
`else
        chk("ovf33_acc", 64'(out_acc_b), 64'h1_7FFF_FFFD);
`endif
        chk("ovf33_cnt", 64'(out_cnt_b), 64'd3);
        idle();
        tick();
        beat(32'd1, 1'b0, 1'b1);
        chk("ovf_cleared", 64'(out_ovf_b), 64'd0);
        idle();
        tick();

        // Long vector: count saturates, sum does not.
        for (int i = 1; i <= 300; i++) begin
            beat(32'd1, 1'b0, (i == 300));
        end
        chk("long_cnt", 64'(out_cnt_a), 64'd255);
        chk("long_acc", 64'(out_acc_a), 64'd300);
        idle();
        tick();

        // Reset mid-vector discards the partial sum.
        beat(32'd50, 1'b0, 1'b0);
        beat(32'd60, 1'b0, 1'b0);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", 64'(out_valid_a), 64'd0);
        chk("rst_mid_ready", 64'(in_ready_a), 64'd1);
        beat(32'd7, 1'b0, 1'b1);
        chk("rst_mid_acc", 64'(out_acc_a), 64'd7);
        chk("rst_mid_cnt", 64'(out_cnt_a), 64'd1);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
